// File: rtl/mem_wb_pkg.sv
// MEM/WB shared definitions: default widths and the packed writeback entry.
// No logic. The entry field order is pc, wb_value, wb_en, dest.
package mem_wb_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     pc;
    logic [DATA_W_DEF-1:0]     wb_value;
    logic                      wb_en;
    logic [REG_ADDR_W_DEF-1:0] dest;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_skid_fifo.sv
// 2-entry skid FIFO with 1-bit pointers. A push is visible one edge later; there is no bypass.
// Full (count 2) blocks pushes. Flush empties the FIFO and takes priority over push and pop.
module wb_skid_fifo
  import mem_wb_pkg::*;
#(
  parameter int unsigned W = WB_ENTRY_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  // The caller gates push with room and pop with occupancy. They are masked again here so a bad caller cannot corrupt the count.
  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (!flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB register stage. It is a 2-entry skid buffer, and a pushed entry reaches the outputs one edge later.
// in_ready depends only on the occupancy register. Defining MEM_WB_FWD_EN adds forwarding outputs taken from the head entry.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_en,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     wb_value,
  output logic                  wb_en_out,
  output logic [REG_ADDR_W-1:0] dest_out
`ifdef MEM_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_value
`endif
);

  wb_entry_t  push_entry, head_entry;
  logic [1:0] count;
  logic       push, pop;

  always_comb begin
    push_entry          = '0;
    push_entry.pc       = pc_in;
    push_entry.wb_value = mem_read ? mem_result : alu_result;
    push_entry.wb_en    = wb_en;
    push_entry.dest     = dest;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  wb_skid_fifo #(.W(WB_ENTRY_W)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (count)
  );

  assign pc_out    = head_entry.pc;
  assign wb_value  = head_entry.wb_value;
  assign dest_out  = head_entry.dest;
  assign wb_en_out = out_valid && head_entry.wb_en;

`ifdef MEM_WB_FWD_EN
  // Writes to register 0 are architecturally discarded, so they are never forwarded.
  assign fwd_valid = out_valid && wb_en_out && (dest_out != '0);
  assign fwd_dest  = dest_out;
  assign fwd_value = wb_value;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage. It runs directed steps and then a random phase.
// Each result is compared against a queue-based model of the stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0, alu_result = '0, mem_result = '0;
  logic        wb_en = 1'b0, mem_read = 1'b0;
  logic [4:0]  dest = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out, wb_value;
  logic        wb_en_out;
  logic [4:0]  dest_out;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_value;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] val;
    logic        en;
    logic [4:0]  dst;
  } ent_t;
  ent_t q[$];

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .alu_result(alu_result), .mem_result(mem_result),
    .wb_en(wb_en), .mem_read(mem_read), .dest(dest), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .wb_value(wb_value), .wb_en_out(wb_en_out), .dest_out(dest_out)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model one rising edge from the inputs and queue contents held just before it.
  task automatic model_edge();
    bit can_push, can_pop;
    ent_t e;
    if (flush) begin
      q.delete();
    end else begin
      can_push = in_valid && (q.size() < 2);
      can_pop  = out_ready && (q.size() != 0);
      if (can_pop) void'(q.pop_front());
      if (can_push) begin
        e.pc = pc_in;
        e.val = mem_read ? mem_result : alu_result;
        e.en = wb_en;
        e.dst = dest;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk({tag, ":wb_en_out"}, 64'(wb_en_out), 64'(q[0].en));
      chk({tag, ":pc_out"}, 64'(pc_out), 64'(q[0].pc));
      chk({tag, ":wb_value"}, 64'(wb_value), 64'(q[0].val));
      chk({tag, ":dest_out"}, 64'(dest_out), 64'(q[0].dst));
    end else begin
      chk({tag, ":wb_en_out_idle"}, 64'(wb_en_out), 64'd0);
    end
`ifdef MEM_WB_FWD_EN
    chk({tag, ":fwd_valid"}, 64'(fwd_valid),
        64'(q.size() != 0 && q[0].en && q[0].dst != 5'd0));
    if (q.size() != 0) chk({tag, ":fwd_value"}, 64'(fwd_value), 64'(q[0].val));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input logic mr, input logic en,
                       input logic [4:0] d, input logic ordy);
    in_valid = v; pc_in = pc; alu_result = alu; mem_result = mem;
    mem_read = mr; wb_en = en; dest = d; out_ready = ordy;
  endtask

  initial begin
    // Hold reset for a while, then check the reset state.
    #12;
    chk("rst:out_valid", 64'(out_valid), 64'd0);
    chk("rst:wb_en_out", 64'(wb_en_out), 64'd0);
    chk("rst:pc_out", 64'(pc_out), 64'd0);
    chk("rst:wb_value", 64'(wb_value), 64'd0);
    chk("rst:dest_out", 64'(dest_out), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst:in_ready", 64'(in_ready), 64'd1);

    // Basic ALU writeback.
    drive(1'b1, 32'h100, 32'h10, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1);
    cycle("alu");
    chk("alu:wb_value_const", 64'(wb_value), 64'h10);
    chk("alu:dest_const", 64'(dest_out), 64'd3);

    // Load data is selected when mem_read is set.
    drive(1'b1, 32'h104, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1, 5'd4, 1'b1);
    cycle("load");
    chk("load:wb_value_const", 64'(wb_value), 64'hDEADBEEF);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle("drain");

    // Fill the buffer under backpressure, then drain it in order.
    drive(1'b1, 32'hA0, 32'hAAAA, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
    cycle("fillA");
    drive(1'b1, 32'hB0, 32'hBBBB, 32'h0, 1'b0, 1'b0, 5'd6, 1'b0);
    cycle("fillB");
    chk("full:in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hC0, 32'hCCCC, 32'h0, 1'b0, 1'b1, 5'd7, 1'b0);
    cycle("full_blocked");
    in_valid = 1'b0; out_ready = 1'b1;
    cycle("popA");
    chk("popA:in_ready", 64'(in_ready), 64'd1);
    chk("popA:head_is_B", 64'(wb_value), 64'hBBBB);
    cycle("popB");

    // A flush while full and pushing discards everything.
    drive(1'b1, 32'hD0, 32'hD0, 32'h0, 1'b0, 1'b1, 5'd8, 1'b0);
    cycle("f1");
    cycle("f2");
    flush = 1'b1;
    cycle("flush");
    chk("flush:out_valid", 64'(out_valid), 64'd0);
    chk("flush:in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    cycle("post_flush");

    // Asserting reset mid-cycle with one entry held clears the outputs at once.
    drive(1'b1, 32'hE0, 32'hE0E0, 32'h0, 1'b0, 1'b1, 5'd9, 1'b0);
    cycle("pre_rst");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:wb_en_out", 64'(wb_en_out), 64'd0);
    chk("midrst:wb_value", 64'(wb_value), 64'd0);
    chk("midrst:pc_out", 64'(pc_out), 64'd0);
    chk("midrst:dest_out", 64'(dest_out), 64'd0);
    #2 rst = 1'b0;
    cycle("post_rst");

`ifdef MEM_WB_FWD_EN
    // Writes to register 0 are not forwarded.
    drive(1'b1, 32'h200, 32'h55, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
    cycle("fwd_r0");
    chk("fwd_r0:fwd_valid", 64'(fwd_valid), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle("fwd_pop");
    drive(1'b1, 32'h204, 32'h77, 32'h0, 1'b0, 1'b1, 5'd7, 1'b0);
    cycle("fwd_r7");
    chk("fwd_r7:fwd_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_r7:fwd_value", 64'(fwd_value), 64'h77);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle("fwd_pop2");
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of PC, ALU result, memory result and writeback value.
REQ-002 Parameter: REG_ADDR_W, 5, destination register index width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: in_valid  input  1  MEM stage presents a valid instruction.
REQ-006 Port: in_ready  output  1  block accepts an entry this cycle.
REQ-007 Port: pc_in  input  DATA_W  PC of instruction leaving MEM.
REQ-008 Port: alu_result  input  DATA_W  ALU result from MEM.
REQ-009 Port: mem_result  input  DATA_W  data-memory read data from MEM.
REQ-010 Port: wb_en, mem_read  input  1 each  writeback enable; select memory data as writeback value.
REQ-011 Port: dest  input  REG_ADDR_W  destination register.
REQ-012 Port: flush  input  1  discard all held entries.
REQ-013 Port: out_valid  output  1  head entry valid toward register-file write port.
REQ-014 Port: out_ready  input  1  register file consumes head entry this cycle.
REQ-015 Port: pc_out, wb_value  output  DATA_W each  head entry PC; selected writeback data.
REQ-016 Port: wb_en_out  output  1  head entry writeback enable, gated by out_valid.
REQ-017 Port: dest_out  output  REG_ADDR_W  head entry destination.

Function
REQ-018 Storage: 2-entry FIFO (skid buffer) of {pc, wb_value, wb_en, dest}; occupancy count 0..2.
REQ-019 wb_value captured at push = mem_read ? mem_result : alu_result; no other arithmetic.
REQ-020 in_ready = (count < 2), driven from registered state only; no combinational path from out_ready or in_valid.
REQ-021 Push when in_valid && in_ready; pop when out_valid && out_ready; out_valid = (count != 0).
REQ-022 Latency: entry pushed at edge N visible on outputs after edge N; no same-cycle input-to-output bypass.
REQ-023 Simultaneous push and pop at count 1: count stays 1, new entry becomes head after pop; order strictly FIFO.
REQ-024 Count 2: push blocked (in_ready low); pop allowed, count goes to 1.
REQ-025 Count 0: pop impossible; out_ready ignored.
REQ-026 Read/write pointers 1 bit, wrap 1->0.
REQ-027 Flush: next edge count=0, pointers=0, simultaneous push discarded, flush dominates push and pop.
REQ-028 wb_en_out = 0 whenever out_valid = 0; pc_out, wb_value, dest_out hold head-slot contents (don't-care when invalid).

Reset
REQ-029 rst asserted: count=0, pointers=0, out_valid=0, wb_en_out=0, storage cleared to 0 so pc_out=wb_value=dest_out=0; in_ready=1 after deassertion.
REQ-030 rst mid-transfer: all entries lost without writeback; no partial entry survives.

Configuration
REQ-031 Macro MEM_WB_FWD_EN defined: extra outputs fwd_valid (1), fwd_dest (REG_ADDR_W), fwd_value (DATA_W) from head entry; fwd_valid = out_valid && wb_en_out && dest_out != 0.
REQ-032 MEM_WB_FWD_EN undefined: forwarding ports absent; all other behaviour identical.

Structure
REQ-033 Shared package holds DATA_W, REG_ADDR_W defaults and the packed WB entry typedef {pc, wb_value, wb_en, dest}.
REQ-034 One sub-module, wb_skid_fifo (2-entry storage, pointers, count); mem_wb_stage adds writeback mux, gating, flush, forwarding.

Verification
REQ-035 Reset then in_valid=1, alu_result=0x10, mem_read=0, dest=3, wb_en=1, out_ready=1 -> next cycle out_valid=1, wb_value=0x10, dest_out=3.
REQ-036 mem_read=1, mem_result=0xDEADBEEF, alu_result=0x40 -> wb_value=0xDEADBEEF.
REQ-037 out_ready=0, push A then B -> in_ready=0 after second edge; raise out_ready -> A then B popped in order, in_ready=1 after first pop.
REQ-038 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed entry not seen.
REQ-039 rst asserted while count=1 mid-cycle -> out_valid and wb_en_out drop immediately, outputs 0.
REQ-040 MEM_WB_FWD_EN defined, head dest=0 wb_en=1 -> fwd_valid=0; dest=7 -> fwd_valid=1, fwd_value=wb_value.
